alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_pkg.sv | 15 +
 rtl/alu_core.sv | 69 ++++++
 rtl/alu_exec.sv | 70 +++++++
 tb/tb_alu_exec.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared constants for the ALU execute stage: datapath width and op_to_alu encodings.
package alu_exec_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operand inversion, adder, shifter, logic ops, pass mux and flags.
module alu_core
    import alu_exec_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    input  logic              inv_a,
    input  logic              inv_b,
    input  logic              cin,
    input  logic              sign_mode,
    input  logic              pass_a,
    input  logic              pass_b,
    output logic [DATA_W-1:0] res,
    output logic              cout,
    output logic              ofl,
    output logic              zero
);

    logic [DATA_W-1:0]   ae;
    logic [DATA_W-1:0]   be;
    logic [DATA_W:0]     sum;
    logic [3:0]          shamt;
    logic [2*DATA_W-1:0] rol_wide;
    logic [2*DATA_W-1:0] ror_wide;
    logic                add_ofl;

    assign ae    = inv_a ? ~a : a;
    assign be    = inv_b ? ~b : b;
    assign sum   = {1'b0, ae} + {1'b0, be} + {{DATA_W{1'b0}}, cin};
    assign shamt = be[3:0];

    // Rotates shift a doubled copy so the wrapped bits fall into the kept half.
    assign rol_wide = {ae, ae} << shamt;
    assign ror_wide = {ae, ae} >> shamt;

    assign add_ofl = sign_mode ? ((ae[DATA_W-1] == be[DATA_W-1]) && (sum[DATA_W-1] != ae[DATA_W-1]))
                               : sum[DATA_W];

    always_comb begin
        res  = '0;
        cout = 1'b0;
        ofl  = 1'b0;
        if (pass_a) begin
            res = ae;
        end else if (pass_b) begin
            res = be;
        end else begin
            case (op)
                OP_ROL: res = rol_wide[2*DATA_W-1:DATA_W];
                OP_SLL: res = ae << shamt;
                OP_ROR: res = ror_wide[DATA_W-1:0];
                OP_SRL: res = ae >> shamt;
                OP_ADD: begin
                    res  = sum[DATA_W-1:0];
                    cout = sum[DATA_W];
                    ofl  = add_ofl;
                end
                OP_OR:  res = ae | be;
                OP_XOR: res = ae ^ be;
                OP_AND: res = ae & be;
                default: res = '0;
            endcase
        end
    end

    assign zero = (res == '0);

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: one-cycle registered ALU with valid/stall/flush handshake.
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        op_to_alu,
    input  logic              invA,
    input  logic              invB,
    input  logic              cin,
    input  logic              sign,
    input  logic              passA,
    input  logic              passB,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              ofl,
    output logic              zero
);

    logic [DATA_W-1:0] core_res;
    logic              core_cout;
    logic              core_ofl;
    logic              core_zero;

    alu_core u_core (
        .a         (A),
        .b         (B),
        .op        (op_to_alu),
        .inv_a     (invA),
        .inv_b     (invB),
        .cin       (cin),
        .sign_mode (sign),
        .pass_a    (passA),
        .pass_b    (passB),
        .res       (core_res),
        .cout      (core_cout),
        .ofl       (core_ofl),
        .zero      (core_zero)
    );

    // Priority: rst, then flush, then stall; data outputs only change on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ofl       <= 1'b0;
            zero      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                out_valid <= 1'b1;
                result    <= core_res;
                cout      <= core_cout;
                ofl       <= core_ofl;
                zero      <= core_zero;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corner vectors plus random traffic against a reference model.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush;
    logic [15:0] A, B;
    logic [2:0]  op_to_alu;
    logic        invA, invB, cin, sign, passA, passB;
    logic        out_valid, cout, ofl, zero;
    logic [15:0] result;

    int n_vec = 0;
    int n_err = 0;

    logic        m_valid;
    logic [15:0] m_res;
    logic        m_cout, m_ofl, m_zero;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .A         (A),
        .B         (B),
        .op_to_alu (op_to_alu),
        .invA      (invA),
        .invB      (invB),
        .cin       (cin),
        .sign      (sign),
        .passA     (passA),
        .passB     (passB),
        .out_valid (out_valid),
        .result    (result),
        .cout      (cout),
        .ofl       (ofl),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU computed with plain integer arithmetic.
    task automatic ref_alu(input int a, input int b, input int op, input bit ia, input bit ib,
                           input bit ci, input bit sg, input bit pa, input bit pb,
                           output int r, output bit c, output bit o);
        int ae, be, s, n, sa, sb, ss;
        ae = ia ? (~a) & 32'hFFFF : a & 32'hFFFF;
        be = ib ? (~b) & 32'hFFFF : b & 32'hFFFF;
        c = 1'b0;
        o = 1'b0;
        n = be % 16;
        if (pa) r = ae;
        else if (pb) r = be;
        else begin
            case (op)
                0: begin r = ae; for (int k = 0; k < n; k++) r = ((r << 1) | (r >> 15)) & 32'hFFFF; end
                1: r = (ae << n) & 32'hFFFF;
                2: begin r = ae; for (int k = 0; k < n; k++) r = ((r >> 1) | ((r & 1) << 15)) & 32'hFFFF; end
                3: r = ae >> n;
                4: begin
                    s  = ae + be + int'(ci);
                    r  = s & 32'hFFFF;
                    c  = (s > 32'hFFFF);
                    sa = (ae >= 32768) ? ae - 65536 : ae;
                    sb = (be >= 32768) ? be - 65536 : be;
                    ss = sa + sb + int'(ci);
                    o  = sg ? (ss > 32767 || ss < -32768) : c;
                end
                5: r = ae | be;
                6: r = ae ^ be;
                default: r = ae & be;
            endcase
        end
    endtask

    task automatic cyc(input bit rs, input bit iv, input bit st, input bit fl,
                       input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input bit ia, input bit ib, input bit ci, input bit sg,
                       input bit pa, input bit pb);
        int r;
        bit c, o;
        rst = rs; in_valid = iv; stall = st; flush = fl;
        A = a; B = b; op_to_alu = op;
        invA = ia; invB = ib; cin = ci; sign = sg; passA = pa; passB = pb;
        @(posedge clk);
        ref_alu(int'(a), int'(b), int'(op), ia, ib, ci, sg, pa, pb, r, c, o);
        if (rs) begin
            m_valid = 0; m_res = 0; m_cout = 0; m_ofl = 0; m_zero = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (!st) begin
            if (iv) begin
                m_valid = 1; m_res = r[15:0]; m_cout = c; m_ofl = o; m_zero = (r == 0);
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("result",    {16'b0, result},    {16'b0, m_res});
        check("cout",      {31'b0, cout},      {31'b0, m_cout});
        check("ofl",       {31'b0, ofl},       {31'b0, m_ofl});
        check("zero",      {31'b0, zero},      {31'b0, m_zero});
    endtask

    task automatic go(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                      input bit ia, input bit ib, input bit ci, input bit sg,
                      input bit pa, input bit pb);
        cyc(0, 1, 0, 0, a, b, op, ia, ib, ci, sg, pa, pb);
    endtask

    initial begin
        logic [15:0] shift_exp [4];
        shift_exp[0] = 16'h0003; shift_exp[1] = 16'h0002;
        shift_exp[2] = 16'hC000; shift_exp[3] = 16'h4000;

        cyc(1, 0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 0, 0);
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", {16'b0, result}, 32'd0);

        // Signed overflow on ADD
        go(16'h7FFF, 16'h0001, 3'd4, 0, 0, 0, 1, 0, 0);
        check("ofl_add_res", {16'b0, result}, 32'h8000);
        check("ofl_add_ofl", {31'b0, ofl}, 32'd1);

        // Subtract to zero
        go(16'h0005, 16'h0005, 3'd4, 1, 0, 1, 1, 0, 0);
        check("sub_zero", {31'b0, zero}, 32'd1);
        check("sub_cout", {31'b0, cout}, 32'd1);

        for (int k = 0; k < 4; k++) begin
            go(16'h8001, 16'h0001, 3'(k), 0, 0, 0, 0, 0, 0);
            check("shift_by1", {16'b0, result}, {16'b0, shift_exp[k]});
            go(16'h8001, 16'h0000, 3'(k), 0, 0, 0, 0, 0, 0);
            check("shift_by0", {16'b0, result}, 32'h8001);
        end

        go(16'hFF0F, 16'h0F0F, 3'd7, 0, 1, 0, 0, 0, 0);
        check("andn", {16'b0, result}, 32'hF000);
        go(16'hAAAA, 16'h1234, 3'd4, 0, 0, 1, 0, 0, 1);
        check("passb", {16'b0, result}, 32'h1234);
        go(16'h5678, 16'h1234, 3'd4, 0, 0, 0, 0, 1, 1);
        check("passa_prio", {16'b0, result}, 32'h5678);

        // Stall holds outputs, then new bundle lands on release
        go(16'd1, 16'd2, 3'd4, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 0, 16'd9, 16'd9, 3'd4, 0, 0, 0, 0, 0, 0);
            check("stall_hold", {16'b0, result}, 32'h0003);
            check("stall_valid", {31'b0, out_valid}, 32'd1);
        end
        go(16'd9, 16'd9, 3'd4, 0, 0, 0, 0, 0, 0);
        check("stall_release", {16'b0, result}, 32'h0012);

        cyc(0, 1, 1, 1, 16'h1111, 16'h2222, 3'd4, 0, 0, 0, 0, 0, 0);
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_hold", {16'b0, result}, 32'h0012);
        go(16'h0001, 16'h0001, 3'd4, 0, 0, 0, 0, 0, 0);
        go(16'h0000, 16'h0000, 3'd5, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 16'hFFFF, 16'h0001, 3'd4, 0, 0, 0, 0, 0, 0);
        check("idle_zero_hold", {31'b0, zero}, 32'd1);
        go(16'hFFFF, 16'h0001, 3'd4, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 16'hFFFF, 16'hFFFF, 3'd4, 0, 0, 0, 0, 0, 0);
        check("rst_result", {16'b0, result}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 10) == 0,
                16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), ($urandom % 8) == 0, ($urandom % 8) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
